// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- parametrised VGA/DVI raster timing generator.
//
// A free-running divider produces p_tick, a one-clk pixel enable every
// CLK_DIV system clocks. Every raster counter, FSM transition and
// registered output advances only on clks where p_tick is high. p_tick
// acts as the valid qualifier for the raster outputs: x/y/syncs/video_on
// hold their values between ticks and are consumed on the clk after the
// edge that sampled p_tick. The generator never stalls and has no ready.
//
// Optional build macro: VGA_PREFETCH_EN adds rd_en/rd_x/rd_y, the raster
// position one tick ahead of x/y, for a 1-tick BRAM read latency.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   en           run request (level)
//   p_tick       pixel enable, one clk wide every CLK_DIV clks
//   hsync/vsync  syncs, active level HS_POL / VS_POL
//   video_on     high in the active area
//   x, y         current raster position
//   line_start   one-clk pulse when x becomes 0 in RUN/DRAIN
//   frame_start  one-clk pulse when x=0 and y=0 become valid
//   frame_cnt    completed-frame count (wraps)
//   running      high in RUN or DRAIN
//   state_dbg    FSM state: 0 IDLE, 1 RUN, 2 DRAIN
//   rd_en, rd_x, rd_y  (VGA_PREFETCH_EN only) next-tick video_on/x/y
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HS_POL    = 0,
  parameter int VS_POL    = 0,
  parameter int XW        = 10,
  parameter int YW        = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  output logic          p_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_cnt,
  output logic          running,
  output logic [1:0]    state_dbg
`ifdef VGA_PREFETCH_EN
  ,
  output logic          rd_en,
  output logic [XW-1:0] rd_x,
  output logic [YW-1:0] rd_y
`endif
);

  localparam int H_TOTAL  = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_DISPLAY + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_DISPLAY + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic HS_LVL = (HS_POL != 0);
  localparam logic VS_LVL = (VS_POL != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [DW-1:0] div_cnt, div_nx;
  logic [XW-1:0] h, h_nx, h_inc;
  logic [YW-1:0] v, v_nx, v_inc;
  logic          h_end, v_end, eof;
  logic          ls_nx, fs_nx, fc_inc;
  logic          run_nx, hs_act, vs_act, vo_nx;

  // Divider: p_tick is registered so it is high exactly in the clks where
  // div_cnt == CLK_DIV-1, and is held low during reset even for CLK_DIV=1.
  always_comb begin
    div_nx = (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      p_tick  <= 1'b0;
    end else begin
      div_cnt <= div_nx;
      p_tick  <= (div_nx == DW'(CLK_DIV - 1));
    end
  end

  // Raster successor of the current position, including both wraps.
  always_comb begin
    h_end = (h == XW'(H_TOTAL - 1));
    v_end = (v == YW'(V_TOTAL - 1));
    eof   = h_end && v_end;
    h_inc = h_end ? '0 : h + XW'(1);
    v_inc = h_end ? (v_end ? '0 : v + YW'(1)) : v;
  end

  // Next state / next raster position / strobes.
  always_comb begin
    state_nx = state;
    h_nx     = h;
    v_nx     = v;
    ls_nx    = 1'b0;
    fs_nx    = 1'b0;
    fc_inc   = 1'b0;
    case (state)
      S_IDLE: begin
        if (en) begin
          state_nx = S_RUN;
          h_nx     = '0;
          v_nx     = '0;
          ls_nx    = 1'b1;
          fs_nx    = 1'b1;
        end
      end
      S_RUN, S_DRAIN: begin
        h_nx     = h_inc;
        v_nx     = v_inc;
        fc_inc   = eof;
        state_nx = en ? S_RUN : S_DRAIN;
        // A drained frame ends quietly in IDLE; otherwise the raster
        // simply continues and the usual strobes fire.
        if (eof && (state == S_DRAIN) && !en) begin
          state_nx = S_IDLE;
        end else begin
          ls_nx = h_end;
          fs_nx = eof;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Decode the position that will be registered, so syncs and x/y move
  // together on the same clk.
  always_comb begin
    run_nx = (state_nx != S_IDLE);
    hs_act = run_nx && (int'(h_nx) >= HS_START) && (int'(h_nx) < HS_END);
    vs_act = run_nx && (int'(v_nx) >= VS_START) && (int'(v_nx) < VS_END);
    vo_nx  = run_nx && (int'(h_nx) < H_DISPLAY) && (int'(v_nx) < V_DISPLAY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      h           <= '0;
      v           <= '0;
      hsync       <= ~HS_LVL;
      vsync       <= ~VS_LVL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else if (p_tick) begin
      state       <= state_nx;
      h           <= h_nx;
      v           <= v_nx;
      hsync       <= hs_act ? HS_LVL : ~HS_LVL;
      vsync       <= vs_act ? VS_LVL : ~VS_LVL;
      video_on    <= vo_nx;
      line_start  <= ls_nx;
      frame_start <= fs_nx;
      if (fc_inc) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  assign x         = h;
  assign y         = v;
  assign running   = (state != S_IDLE);
  assign state_dbg = state;

`ifdef VGA_PREFETCH_EN
  // Look-ahead assumes the current state persists; the only landing in
  // IDLE that can be predicted is the end of a draining frame.
  assign rd_x  = (state != S_IDLE) ? h_inc : '0;
  assign rd_y  = (state != S_IDLE) ? v_inc : '0;
  assign rd_en = ((state == S_RUN) || ((state == S_DRAIN) && !eof)) &&
                 (int'(h_inc) < H_DISPLAY) && (int'(v_inc) < V_DISPLAY);
`endif

endmodule
